wb_master_bridge: RTL

- Wishbone classic single-transfer initiator: converts a valid/ready command stream into one Wishbone cycle per command.
- Returns read data or completion status on a valid/ready response stream.
- Sits in front of the user-area bus splitter so an on-chip agent (UART debug, DMA sequencer, LA-driven test harness) can drive the PWM/timer slaves without the management SoC.
- Provides ack/err handling, a bus-timeout watchdog and alignment checking.

---
 rtl/wb_master_pkg.sv | 23 ++
 rtl/wb_master_bridge_if.sv | 52 +++++
 rtl/wb_master_bridge.sv | 124 ++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared encodings for the Wishbone single-transfer initiator: response status
// codes, FSM states and the default watchdog limit.
package wb_master_pkg;

  localparam logic [1:0] ST_OK         = 2'd0;
  localparam logic [1:0] ST_BUS_ERR    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT    = 2'd2;
  localparam logic [1:0] ST_MISALIGNED = 2'd3;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Only word-wide buses enforce alignment; narrower buses accept any address.
  function automatic logic is_misaligned(input int unsigned dw, input logic [1:0] lsb);
    return (dw == 32) && (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/wb_master_bridge_if.sv
// Command/response streams plus Wishbone master signals of the bridge.
// The master modport is the bridge side; slave is the surrounding environment.
interface wb_master_bridge_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic            cmd_we_i;
  logic [AW-1:0]   cmd_adr_i;
  logic [DW-1:0]   cmd_dat_i;
  logic [DW/8-1:0] cmd_sel_i;

  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [DW-1:0]   rsp_dat_o;
  logic [1:0]      rsp_status_o;

  logic            wbm_cyc_o;
  logic            wbm_stb_o;
  logic            wbm_we_o;
  logic [AW-1:0]   wbm_adr_o;
  logic [DW-1:0]   wbm_dat_o;
  logic [DW/8-1:0] wbm_sel_o;
  logic [DW-1:0]   wbm_dat_i;
  logic            wbm_ack_i;
  logic            wbm_err_i;

  logic            busy_o;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  rsp_ready_i,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    output busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o,
    output rsp_ready_i,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  busy_o
  );

endinterface

// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer initiator: one bus cycle per accepted command,
// with err/ack termination, a bus-timeout watchdog and alignment checking.
module wb_master_bridge
  import wb_master_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  wb_master_bridge_if.master   bus
);

  localparam int unsigned CW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];

  state_t          state, state_nxt;
  logic            cap;
  logic            rsp_load;
  logic [1:0]      status_nxt;
  logic [DW-1:0]   dat_nxt;
  logic            to_hit;

  logic            we_q;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   dat_q;
  logic [DW/8-1:0] sel_q;
  logic [DW-1:0]   rsp_dat_q;
  logic [1:0]      rsp_status_q;
  logic [CW-1:0]   cnt;

  assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= IDLE;
    else             state <= state_nxt;
  end

  // Termination priority inside BUS: err, then ack, then watchdog expiry.
  always_comb begin
    state_nxt  = state;
    cap        = 1'b0;
    rsp_load   = 1'b0;
    status_nxt = ST_OK;
    dat_nxt    = '0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          cap = 1'b1;
          if (is_misaligned(DW, bus.cmd_adr_i[1:0])) begin
            state_nxt  = RESP;
            rsp_load   = 1'b1;
            status_nxt = ST_MISALIGNED;
          end else begin
            state_nxt = BUS;
          end
        end
      end
      BUS: begin
        if (bus.wbm_err_i) begin
          state_nxt  = RESP;
          rsp_load   = 1'b1;
          status_nxt = ST_BUS_ERR;
        end else if (bus.wbm_ack_i) begin
          state_nxt  = RESP;
          rsp_load   = 1'b1;
          status_nxt = ST_OK;
          dat_nxt    = we_q ? '0 : bus.wbm_dat_i;
        end else if (to_hit) begin
          state_nxt  = RESP;
          rsp_load   = 1'b1;
          status_nxt = ST_TIMEOUT;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
      cnt          <= '0;
    end else begin
      if (cap) begin
        we_q  <= bus.cmd_we_i;
        adr_q <= bus.cmd_adr_i;
        dat_q <= bus.cmd_dat_i;
        sel_q <= bus.cmd_sel_i;
        cnt   <= '0;
      end else if (state == BUS && cnt != '1) begin
        cnt <= cnt + CW'(1);
      end
      if (rsp_load) begin
        rsp_dat_q    <= dat_nxt;
        rsp_status_q <= status_nxt;
      end
    end
  end

  // Bus strobes come straight from the state register, so they are glitch-free
  // and fall asynchronously on reset.
  assign bus.cmd_ready_o  = (state == IDLE);
  assign bus.rsp_valid_o  = (state == RESP);
  assign bus.busy_o       = (state != IDLE);
  assign bus.wbm_cyc_o    = (state == BUS);
  assign bus.wbm_stb_o    = (state == BUS);
  assign bus.wbm_we_o     = (state == BUS) && we_q;
  assign bus.wbm_adr_o    = adr_q;
  assign bus.wbm_dat_o    = dat_q;
  assign bus.wbm_sel_o    = sel_q;
  assign bus.rsp_dat_o    = rsp_dat_q;
  assign bus.rsp_status_o = rsp_status_q;

endmodule
